// File: rtl/afe_buff_arbiter_if.sv
// Bundle between the AFE readout instances, the sample-buffer arbiter and its SRAM.
// master = requesters plus SRAM model, slave = arbiter.
interface afe_buff_arbiter_if #(
    parameter int unsigned NUM_RX     = 2,
    parameter int unsigned AWIDTH     = 10,
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned MEM_AWIDTH = 11
);
    logic [NUM_RX-1:0]             wr_valid_i;
    logic [NUM_RX-1:0][AWIDTH-1:0] wr_addr_i;
    logic [NUM_RX-1:0][DWIDTH-1:0] wr_data_i;
    logic [NUM_RX-1:0]             wr_ready_o;
    logic [NUM_RX-1:0]             rd_valid_i;
    logic [NUM_RX-1:0][AWIDTH-1:0] rd_addr_i;
    logic [NUM_RX-1:0]             rd_ready_o;
    logic [NUM_RX-1:0]             rd_rvalid_o;
    logic [DWIDTH-1:0]             rd_rdata_o;
    logic                          mem_req_o;
    logic                          mem_we_o;
    logic [MEM_AWIDTH-1:0]         mem_addr_o;
    logic [DWIDTH-1:0]             mem_wdata_o;
    logic [DWIDTH-1:0]             mem_rdata_i;
    logic                          starve_event_o;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i, mem_rdata_i,
        input  wr_ready_o, rd_ready_o, rd_rvalid_o, rd_rdata_o, mem_req_o, mem_we_o,
        input  mem_addr_o, mem_wdata_o, starve_event_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i, mem_rdata_i,
        output wr_ready_o, rd_ready_o, rd_rvalid_o, rd_rdata_o, mem_req_o, mem_we_o,
        output mem_addr_o, mem_wdata_o, starve_event_o
    );
endinterface

// File: rtl/afe_buff_arbiter.sv
// Single-port sample-buffer SRAM arbiter: write-priority round-robin with a
// read-starvation guard and one-cycle registered read return.
module afe_buff_arbiter #(
    parameter int unsigned NUM_RX          = 2,
    parameter int unsigned AWIDTH          = 10,
    parameter int unsigned DWIDTH          = 32,
    parameter int unsigned RD_STARVE_LIMIT = 8,
    parameter int unsigned CNT_WIDTH       = 4,
    localparam int unsigned IDW            = $clog2(NUM_RX),
    localparam int unsigned MEM_AWIDTH     = AWIDTH + IDW
) (
    input logic               clk_i,
    input logic               rst_ni,
    input logic               test_mode_i,
    afe_buff_arbiter_if.slave bus
);

    logic [IDW-1:0]       wr_rr_q, wr_rr_d, rd_rr_q, rd_rr_d;
    logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [NUM_RX-1:0]    rd_rvalid_q;
    logic                 starve_event_q;

    logic                 any_wr, any_rd, starve;
    logic                 wr_gnt, rd_gnt;
    logic [IDW-1:0]       wr_idx, rd_idx;
    logic [NUM_RX-1:0]    wr_ready, rd_ready;
    logic                 unused_test_mode;

    assign unused_test_mode = test_mode_i;

    // First requester at or above ptr, wrapping; lowest offset wins.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_RX-1:0] req,
                                               input logic [IDW-1:0]    ptr);
        logic [IDW-1:0] idx;
        int unsigned    c;
        idx = ptr;
        for (int unsigned k = NUM_RX; k > 0; k--) begin
            c = (32'(ptr) + k - 1) % NUM_RX;
            if (req[IDW'(c)]) idx = IDW'(c);
        end
        return idx;
    endfunction

    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] idx);
        return (idx == IDW'(NUM_RX - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        any_wr = |bus.wr_valid_i;
        any_rd = |bus.rd_valid_i;
        starve = (RD_STARVE_LIMIT != 0) && (wait_cnt_q == CNT_WIDTH'(RD_STARVE_LIMIT)) && any_rd;
        // Grants are forced low while reset is held so every output reads 0.
        wr_gnt = rst_ni && any_wr && !starve;
        rd_gnt = rst_ni && any_rd && (starve || !any_wr);
        wr_idx = rr_pick(bus.wr_valid_i, wr_rr_q);
        rd_idx = rr_pick(bus.rd_valid_i, rd_rr_q);

        wr_ready = '0;
        rd_ready = '0;
        if (wr_gnt) wr_ready = NUM_RX'(1) << wr_idx;
        if (rd_gnt) rd_ready = NUM_RX'(1) << rd_idx;

        wr_rr_d = wr_gnt ? rr_next(wr_idx) : wr_rr_q;
        rd_rr_d = rd_gnt ? rr_next(rd_idx) : rd_rr_q;

        wait_cnt_d = wait_cnt_q;
        if (rd_gnt || !any_rd) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_WIDTH'(RD_STARVE_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.wr_ready_o  = wr_ready;
        bus.rd_ready_o  = rd_ready;
        bus.mem_req_o   = wr_gnt || rd_gnt;
        bus.mem_we_o    = wr_gnt;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (wr_gnt) begin
            bus.mem_addr_o  = {wr_idx, bus.wr_addr_i[wr_idx]};
            bus.mem_wdata_o = bus.wr_data_i[wr_idx];
        end else if (rd_gnt) begin
            bus.mem_addr_o  = {rd_idx, bus.rd_addr_i[rd_idx]};
        end
        bus.rd_rvalid_o    = rd_rvalid_q;
        bus.rd_rdata_o     = (|rd_rvalid_q) ? bus.mem_rdata_i : '0;
        bus.starve_event_o = starve_event_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_rr_q        <= '0;
            rd_rr_q        <= '0;
            wait_cnt_q     <= '0;
            rd_rvalid_q    <= '0;
            starve_event_q <= 1'b0;
        end else begin
            wr_rr_q        <= wr_rr_d;
            rd_rr_q        <= rd_rr_d;
            wait_cnt_q     <= wait_cnt_d;
            rd_rvalid_q    <= rd_ready;
            starve_event_q <= starve;
        end
    end

endmodule

// File: tb/tb_afe_buff_arbiter.sv
// Directed bench for afe_buff_arbiter: one instance with the starvation guard at 8,
// one with it disabled, both driven with identical requests.
module tb_afe_buff_arbiter;

    logic clk;
    logic rst_ni;
    logic test_mode;
    int   total = 0;
    int   bad   = 0;

    afe_buff_arbiter_if #(.NUM_RX(2), .AWIDTH(10), .DWIDTH(32), .MEM_AWIDTH(11)) ifa ();
    afe_buff_arbiter_if #(.NUM_RX(2), .AWIDTH(10), .DWIDTH(32), .MEM_AWIDTH(11)) ifb ();

    afe_buff_arbiter #(
        .NUM_RX(2), .AWIDTH(10), .DWIDTH(32), .RD_STARVE_LIMIT(8), .CNT_WIDTH(4)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(test_mode), .bus(ifa.slave)
    );

    afe_buff_arbiter #(
        .NUM_RX(2), .AWIDTH(10), .DWIDTH(32), .RD_STARVE_LIMIT(0), .CNT_WIDTH(4)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(test_mode), .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (ifa.mem_req_o) begin
            if (ifa.mem_we_o) mem[ifa.mem_addr_o] <= ifa.mem_wdata_o;
            else              ifa.mem_rdata_i     <= mem[ifa.mem_addr_o];
        end
    end
    assign ifb.mem_rdata_i = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wv, input logic [1:0] rv);
        ifa.wr_valid_i = wv;
        ifb.wr_valid_i = wv;
        ifa.rd_valid_i = rv;
        ifb.rd_valid_i = rv;
    endtask

    task automatic step(input logic [1:0] wv, input logic [1:0] rv);
        @(negedge clk);
        drive(wv, rv);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        drive(2'b00, 2'b00);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        int wcount;
        logic [1:0] exp_w;
        rst_ni    = 1'b0;
        test_mode = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[11'h405] = 32'hCAFE_0001;
        mem[11'h007] = 32'h1234_5678;
        ifa.mem_rdata_i = '0;
        ifa.wr_addr_i[0] = 10'h03A;  ifa.wr_addr_i[1] = 10'h1C5;
        ifa.wr_data_i[0] = 32'hA0A0_0000;  ifa.wr_data_i[1] = 32'hB1B1_1111;
        ifa.rd_addr_i[0] = 10'h007;  ifa.rd_addr_i[1] = 10'h005;
        ifb.wr_addr_i = ifa.wr_addr_i;
        ifb.wr_data_i = ifa.wr_data_i;
        ifb.rd_addr_i = ifa.rd_addr_i;
        drive(2'b11, 2'b11);

        // Reset held with every valid high
        step(2'b11, 2'b11);
        chk("rst_wr_ready", 32'(ifa.wr_ready_o), 32'h0);
        chk("rst_rd_ready", 32'(ifa.rd_ready_o), 32'h0);
        chk("rst_mem_req", 32'(ifa.mem_req_o), 32'h0);
        chk("rst_mem_addr", 32'(ifa.mem_addr_o), 32'h0);
        chk("rst_mem_wdata", ifa.mem_wdata_o, 32'h0);
        chk("rst_rvalid", 32'(ifa.rd_rvalid_o), 32'h0);
        chk("rst_rdata", ifa.rd_rdata_o, 32'h0);
        chk("rst_starve", 32'(ifa.starve_event_o), 32'h0);

        @(negedge clk);
        rst_ni = 1'b1;
        drive(2'b11, 2'b11);
        #1;
        chk("rel_wr_ready", 32'(ifa.wr_ready_o), 32'h1);
        chk("rel_mem_we", 32'(ifa.mem_we_o), 32'h1);
        chk("rel_mem_addr", 32'(ifa.mem_addr_o), 32'h03A);
        chk("rel_mem_wdata", ifa.mem_wdata_o, 32'hA0A0_0000);
        chk("rel_rd_ready", 32'(ifa.rd_ready_o), 32'h0);

        // Two writers back to back alternate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'b00);
            chk("rr_wr_ready", 32'(ifa.wr_ready_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_mem_addr", 32'(ifa.mem_addr_o), (i % 2 == 0) ? 32'h03A : 32'h5C5);
            chk("rr_rd_ready", 32'(ifa.rd_ready_o), 32'h0);
        end

        // Single read from instance 1
        do_reset();
        step(2'b00, 2'b10);
        chk("rd1_rd_ready", 32'(ifa.rd_ready_o), 32'h2);
        chk("rd1_mem_addr", 32'(ifa.mem_addr_o), 32'h405);
        chk("rd1_mem_we", 32'(ifa.mem_we_o), 32'h0);
        chk("rd1_mem_req", 32'(ifa.mem_req_o), 32'h1);
        step(2'b00, 2'b00);
        chk("rd1_rvalid", 32'(ifa.rd_rvalid_o), 32'h2);
        chk("rd1_rdata", ifa.rd_rdata_o, 32'hCAFE_0001);
        chk("rd1_rd_ready_idle", 32'(ifa.rd_ready_o), 32'h0);
        step(2'b00, 2'b00);
        chk("rd1_rvalid_clr", 32'(ifa.rd_rvalid_o), 32'h0);
        chk("rd1_rdata_clr", ifa.rd_rdata_o, 32'h0);

        // Starvation guard: forced reads at cycles 8 and 17; guard off never reads
        do_reset();
        wcount = 0;
        for (int c = 0; c < 18; c++) begin
            step(2'b11, 2'b01);
            if (c == 8 || c == 17) begin
                exp_w = 2'b00;
            end else begin
                exp_w = (wcount % 2 == 0) ? 2'b01 : 2'b10;
                wcount++;
            end
            chk("stv_wr_ready", 32'(ifa.wr_ready_o), 32'(exp_w));
            chk("stv_rd_ready", 32'(ifa.rd_ready_o), (c == 8 || c == 17) ? 32'h1 : 32'h0);
            chk("stv_event", 32'(ifa.starve_event_o), (c == 9) ? 32'h1 : 32'h0);
            chk("stv_rvalid", 32'(ifa.rd_rvalid_o), (c == 9) ? 32'h1 : 32'h0);
            if (c == 9) chk("stv_rdata", ifa.rd_rdata_o, 32'h1234_5678);
            chk("noguard_wr_ready", 32'(ifb.wr_ready_o), (c % 2 == 0) ? 32'h1 : 32'h2);
            chk("noguard_rd_ready", 32'(ifb.rd_ready_o), 32'h0);
            chk("noguard_event", 32'(ifb.starve_event_o), 32'h0);
        end

        // Reset right after a read grant discards the return and clears pointers
        do_reset();
        step(2'b01, 2'b00);
        chk("mid_wr_ready", 32'(ifa.wr_ready_o), 32'h1);
        step(2'b00, 2'b01);
        chk("mid_rd_ready", 32'(ifa.rd_ready_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rd_ready_rst", 32'(ifa.rd_ready_o), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rvalid_rst", 32'(ifa.rd_rvalid_o), 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        drive(2'b11, 2'b00);
        #1;
        chk("mid_rvalid_after", 32'(ifa.rd_rvalid_o), 32'h0);
        chk("mid_wr_ptr", 32'(ifa.wr_ready_o), 32'h1);
        step(2'b00, 2'b11);
        chk("mid_rd_ptr", 32'(ifa.rd_ready_o), 32'h1);
        step(2'b00, 2'b00);
        chk("mid_rvalid_new", 32'(ifa.rd_rvalid_o), 32'h1);
        chk("mid_rdata_new", ifa.rd_rdata_o, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
